// File: rtl/load_extend_unit_pkg.sv
// Shared load-path encodings.
//   MEM_BYTE / MEM_HALF / MEM_WORD : mem_op access-size codes (2'b11 reserved)
//   EXT_ZERO / EXT_SIGN           : mem_ext extension-mode codes
package load_extend_unit_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/load_extend_unit_if.sv
// Load-extend bus bundle.
//   Request side : in_valid, mem_op[1:0], mem_ext, byte_off[1:0], word_in[31:0]
//   Direct ext   : ext8_in[7:0], ext16_in[15:0] -> ext8_out[31:0], ext16_out[31:0]
//   Result side  : out_valid, dout[31:0], misalign
// master = requester (drives request/direct operands), slave = load_extend_unit.
interface load_extend_unit_if;

    logic        in_valid;
    logic [1:0]  mem_op;
    logic        mem_ext;
    logic [1:0]  byte_off;
    logic [31:0] word_in;
    logic [7:0]  ext8_in;
    logic [15:0] ext16_in;
    logic [31:0] ext8_out;
    logic [31:0] ext16_out;
    logic        out_valid;
    logic [31:0] dout;
    logic        misalign;

    modport master (
        output in_valid, mem_op, mem_ext, byte_off, word_in, ext8_in, ext16_in,
        input  ext8_out, ext16_out, out_valid, dout, misalign
    );

    modport slave (
        input  in_valid, mem_op, mem_ext, byte_off, word_in, ext8_in, ext16_in,
        output ext8_out, ext16_out, out_valid, dout, misalign
    );

endinterface

// File: rtl/load_extend_unit_ext.sv
// ext_n_to_32: combinational N-bit to 32-bit extender.
//   din_i[N-1:0]  operand
//   sign_i        1: replicate din_i MSB into upper bits, 0: zero-fill
//   dout_o[31:0]  extended result
module ext_n_to_32 #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] din_i,
    input  logic         sign_i,
    output logic [31:0]  dout_o
);

    logic fill;

    assign fill   = sign_i & din_i[N-1];
    assign dout_o = {{(32 - N){fill}}, din_i};

endmodule

// File: rtl/load_extend_unit.sv
// load_extend_unit: load-path lane extractor/extender with one-cycle registered result.
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : load_extend_unit_if.slave (request, direct extender operands/results,
//           registered out_valid/dout/misalign)
module load_extend_unit
    import load_extend_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    load_extend_unit_if.slave    bus
);

    logic        sign_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] byte_ext;
    logic [31:0] half_ext;
    logic [31:0] res_d;
    logic        mis_d;
    logic [31:0] dout_q;
    logic        mis_q;
    logic        valid_q;

    assign sign_ext = (bus.mem_ext == EXT_SIGN);

    // Free-standing extenders offered to other users of the bus.
    ext_n_to_32 #(.N(8)) u_ext8_direct (
        .din_i  (bus.ext8_in),
        .sign_i (sign_ext),
        .dout_o (bus.ext8_out)
    );

    ext_n_to_32 #(.N(16)) u_ext16_direct (
        .din_i  (bus.ext16_in),
        .sign_i (sign_ext),
        .dout_o (bus.ext16_out)
    );

    // Lane select: little-endian, byte0 = word_in[7:0].
    always_comb begin
        byte_lane = bus.word_in[7:0];
        case (bus.byte_off)
            2'd0:    byte_lane = bus.word_in[7:0];
            2'd1:    byte_lane = bus.word_in[15:8];
            2'd2:    byte_lane = bus.word_in[23:16];
            default: byte_lane = bus.word_in[31:24];
        endcase
    end

    // byte_off[0] is only meaningful for the misalign check; bit 1 picks the half.
    assign half_lane = bus.byte_off[1] ? bus.word_in[31:16] : bus.word_in[15:0];

    ext_n_to_32 #(.N(8)) u_ext8_lane (
        .din_i  (byte_lane),
        .sign_i (sign_ext),
        .dout_o (byte_ext)
    );

    ext_n_to_32 #(.N(16)) u_ext16_lane (
        .din_i  (half_lane),
        .sign_i (sign_ext),
        .dout_o (half_ext)
    );

    // Result/misalign decode; illegal requests return zero data.
    always_comb begin
        res_d = '0;
        mis_d = 1'b0;
        case (bus.mem_op)
            MEM_BYTE: res_d = byte_ext;
            MEM_HALF: begin
                if (bus.byte_off[0]) begin
                    mis_d = 1'b1;
                end else begin
                    res_d = half_ext;
                end
            end
            MEM_WORD: res_d = bus.word_in;
            default:  mis_d = 1'b1;
        endcase
    end

    // Output register: data/misalign only update on a valid request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                dout_q <= res_d;
                mis_q  <= mis_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.dout      = dout_q;
    assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_load_extend_unit.sv
module tb_load_extend_unit;

    typedef struct {
        logic [1:0]  op;
        logic        ext;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp_dout;
        logic        exp_mis;
    } vec_t;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    vec_t vecs[$];

    load_extend_unit_if bus();

    load_extend_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic ext, input logic [1:0] off,
                       input logic [31:0] word, input logic [31:0] exp_dout, input logic exp_mis);
        vec_t v;
        v.op = op; v.ext = ext; v.off = off; v.word = word;
        v.exp_dout = exp_dout; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic ext,
                         input logic [1:0] off, input logic [31:0] word);
        bus.in_valid = vld;
        bus.mem_op   = op;
        bus.mem_ext  = ext;
        bus.byte_off = off;
        bus.word_in  = word;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 2'd0, 32'h0);
        bus.ext8_in  = 8'h00;
        bus.ext16_in = 16'h0000;

        // Byte lanes, sign-extended then zero-extended
        add(2'b00, 1'b1, 2'd0, 32'h80FF7F01, 32'h00000001, 1'b0);
        add(2'b00, 1'b1, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0);
        add(2'b00, 1'b1, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0);
        add(2'b00, 1'b1, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0);
        add(2'b00, 1'b0, 2'd0, 32'h80FF7F01, 32'h00000001, 1'b0);
        add(2'b00, 1'b0, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0);
        add(2'b00, 1'b0, 2'd2, 32'h80FF7F01, 32'h000000FF, 1'b0);
        add(2'b00, 1'b0, 2'd3, 32'h80FF7F01, 32'h00000080, 1'b0);
        // Half lanes
        add(2'b01, 1'b1, 2'd0, 32'h80017FFE, 32'h00007FFE, 1'b0);
        add(2'b01, 1'b1, 2'd2, 32'h80017FFE, 32'hFFFF8001, 1'b0);
        add(2'b01, 1'b0, 2'd2, 32'h80017FFE, 32'h00008001, 1'b0);
        add(2'b01, 1'b1, 2'd0, 32'h1234F00D, 32'hFFFFF00D, 1'b0);
        add(2'b01, 1'b0, 2'd0, 32'h1234F00D, 32'h0000F00D, 1'b0);
        // Misaligned half and reserved op
        add(2'b01, 1'b1, 2'd1, 32'h80017FFE, 32'h00000000, 1'b1);
        add(2'b01, 1'b0, 2'd3, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        add(2'b11, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        // Word: offset and ext ignored
        add(2'b10, 1'b1, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        add(2'b10, 1'b0, 2'd1, 32'h80000001, 32'h80000001, 1'b0);

        // Reset state
        #2;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_dout", bus.dout, 32'h0);
        check("rst_mis", {31'd0, bus.misalign}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table vectors: apply after an edge, check after the next
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].op, vecs[i].ext, vecs[i].off, vecs[i].word);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_mis", i), {31'd0, bus.misalign}, {31'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
        end

        // Hold after word: in_valid low keeps dout, drops out_valid
        drive(1'b0, 2'b00, 1'b1, 2'd2, 32'h12345678);
        @(posedge clk);
        #1;
        check("hold_valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold_dout", bus.dout, 32'h80000001);
        check("hold_mis", {31'd0, bus.misalign}, 32'd0);

        // Hold of misalign flag
        drive(1'b1, 2'b11, 1'b0, 2'd0, 32'hAAAA5555);
        @(posedge clk);
        #1;
        check("mis_set", {31'd0, bus.misalign}, 32'd1);
        drive(1'b0, 2'b10, 1'b0, 2'd0, 32'hAAAA5555);
        @(posedge clk);
        #1;
        check("mis_hold", {31'd0, bus.misalign}, 32'd1);
        check("mis_hold_dout", bus.dout, 32'h0);
        check("mis_hold_valid", {31'd0, bus.out_valid}, 32'd0);

        // Direct extenders, no clock edge between settings
        @(negedge clk);
        bus.ext8_in  = 8'h80;
        bus.ext16_in = 16'h8000;
        bus.mem_ext  = 1'b1;
        bus.mem_op   = 2'b11;
        #1;
        check("ext8_sign", bus.ext8_out, 32'hFFFFFF80);
        check("ext16_sign", bus.ext16_out, 32'hFFFF8000);
        bus.mem_ext = 1'b0;
        #1;
        check("ext8_zero", bus.ext8_out, 32'h00000080);
        check("ext16_zero", bus.ext16_out, 32'h00008000);
        bus.ext8_in  = 8'h7F;
        bus.ext16_in = 16'h7FFF;
        bus.mem_ext  = 1'b1;
        #1;
        check("ext8_pos", bus.ext8_out, 32'h0000007F);
        check("ext16_pos", bus.ext16_out, 32'h00007FFF);

        // Asynchronous reset mid-stream with in_valid high
        @(posedge clk);
        #1;
        drive(1'b1, 2'b10, 1'b0, 2'd0, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("pre_rst_dout", bus.dout, 32'hCAFEF00D);
        drive(1'b1, 2'b01, 1'b1, 2'd1, 32'hCAFEF00D);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_dout", bus.dout, 32'h0);
        check("arst_mis", {31'd0, bus.misalign}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_held_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 2'd3, 32'h80FF7F01);
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("post_rst_dout", bus.dout, 32'hFFFFFF80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
